se_pc_ctrl: RTL and testbench

//  Next-PC sequencer and instruction-fetch controller for the se_pc register. Each cycle it drives npc_o into se_pc.pci_i.
//  It reads back the current PC from se_pc.pco_o and runs the req/gnt/rvalid handshake to instruction memory.
//  It arbitrates PC redirects in fixed priority: trap, trap-return, branch, sequential. Sits between se_pc and decode in the fetch stage.

---
 rtl/se_pkg.sv | 19 +
 rtl/se_npc_sel.sv | 36 +++
 rtl/se_pc_ctrl.sv | 157 +++++++++++++++
 tb/tb_se_pc_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/se_pkg.sv
// Shared constants and types for the fetch-stage PC controller.
package se_pkg;

    localparam int XLEN        = 64;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_VEC = 64'h0000_0000_0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC  = 64'h0000_0000_0000_0100;

    // INSTR_BYTES is a power of two, so alignment is a low-bit mask test.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FLUSH} pc_state_e;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/se_npc_sel.sv
// Fixed-priority next-PC target mux: trap, trap-return, branch, sequential.
// A misaligned branch target is turned into a trap to TRAP_VEC.
module se_npc_sel
    import se_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            trap_i,
    input  logic            trap_ret_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

    // Priority selection; sequential increment wraps modulo 2^XLEN.
    always_comb begin
        redirect_o = trap_i | trap_ret_i | br_taken_i;
        misalign_o = 1'b0;
        target_o   = pc_i + XLEN'(INSTR_BYTES);
        if (trap_i) begin
            target_o = TRAP_VEC;
        end else if (trap_ret_i) begin
            target_o = mepc_i;
        end else if (br_taken_i) begin
            if (is_misaligned(br_target_i)) begin
                misalign_o = 1'b1;
                target_o   = TRAP_VEC;
            end else begin
                target_o = br_target_i;
            end
        end
    end

endmodule

// File: rtl/se_pc_ctrl.sv
// Next-PC sequencer and instruction-fetch handshake controller for se_pc.
module se_pc_ctrl
    import se_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] npc_o,
    output logic            if_req_o,
    output logic [XLEN-1:0] if_addr_o,
    input  logic            if_gnt_i,
    input  logic            if_rvalid_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] fetch_pc_o,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            trap_ret_i,
    output logic [XLEN-1:0] mepc_o,
    output logic            misalign_o
);

    pc_state_e       state_reg, state_next;
    logic [XLEN-1:0] pend_reg, pend_next;
    logic            pend_valid_reg, pend_valid_next;
    logic [XLEN-1:0] mepc_reg;
    logic            misalign_reg;

    logic            redirect;
    logic [XLEN-1:0] sel_target;
    logic            sel_misalign;
    logic            accept;

    // Redirects are ignored while idle; everywhere else they take effect.
    assign accept = (state_reg != IDLE);

    se_npc_sel u_npc_sel (
        .pc_i        (pc_i),
        .trap_i      (trap_i),
        .trap_ret_i  (trap_ret_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .mepc_i      (mepc_reg),
        .redirect_o  (redirect),
        .target_o    (sel_target),
        .misalign_o  (sel_misalign)
    );

    // State, pending redirect and exception-PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            mepc_reg       <= '0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            misalign_reg   <= accept & sel_misalign;
            if (accept && trap_i) begin
                mepc_reg <= epc_i;
            end else if (accept && sel_misalign) begin
                mepc_reg <= pc_i;
            end
        end
    end

    // Next-state and output decode; reset forces the idle outputs immediately.
    always_comb begin
        state_next      = state_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        npc_o           = pc_i;
        if_req_o        = 1'b0;
        if_addr_o       = pc_i;
        fetch_valid_o   = 1'b0;
        fetch_pc_o      = pc_i;

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                // Request and address must stay stable until granted, so a
                // redirect is parked in pend_reg and applied at grant time.
                if_req_o = 1'b1;
                if (if_gnt_i) begin
                    pend_valid_next = 1'b0;
                    if (redirect) begin
                        npc_o      = sel_target;
                        state_next = FLUSH;
                    end else if (pend_valid_reg) begin
                        npc_o      = pend_reg;
                        state_next = FLUSH;
                    end else begin
                        state_next = WAIT;
                    end
                end else if (redirect) begin
                    pend_next       = sel_target;
                    pend_valid_next = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    npc_o      = sel_target;
                    state_next = if_rvalid_i ? REQ : FLUSH;
                end else if (if_rvalid_i) begin
                    fetch_valid_o = 1'b1;
                    if (stall_i) begin
                        state_next = HOLD;
                    end else begin
                        npc_o      = sel_target;
                        state_next = REQ;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    npc_o      = sel_target;
                    state_next = REQ;
                end else begin
                    fetch_valid_o = 1'b1;
                    if (!stall_i) begin
                        npc_o      = sel_target;
                        state_next = REQ;
                    end
                end
            end
            FLUSH: begin
                // The in-flight response belongs to a stale address.
                if (redirect) begin
                    npc_o = sel_target;
                end
                if (if_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!rst_n) begin
            npc_o         = RESET_VEC;
            if_req_o      = 1'b0;
            fetch_valid_o = 1'b0;
        end
    end

    assign mepc_o     = mepc_reg;
    assign misalign_o = misalign_reg;

endmodule

// File: tb/tb_se_pc_ctrl.sv
// Self-checking bench for se_pc_ctrl: cycle-vector table plus hand-written
// trap / misalign / wrap / async-reset sequences, with a fetch-PC scoreboard.
module tb_se_pc_ctrl;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [63:0] E  = 64'hDEAD_BEEF_C001_CAFE;
    localparam logic [63:0] E4 = 64'hDEAD_BEEF_C001_CB02;
    localparam logic [63:0] WR = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic [63:0] pc, npc, if_addr, fetch_pc, br_target, epc, mepc;
    logic        if_req, if_gnt, if_rvalid, fetch_valid, stall;
    logic        br_taken, trap, trap_ret, misalign;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        gnt, rvalid, stall, br;
        logic [63:0] tgt;
        logic        trap, ret;
        logic [63:0] epc;
        logic        deliver;
        logic        exp_req;
        logic [63:0] exp_pc;
        logic        exp_fv;
        logic [63:0] exp_npc;
        logic        exp_mis;
        logic [63:0] exp_mepc;
    } vec_t;

    vec_t tbl[$];

    se_pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc),
        .npc_o         (npc),
        .if_req_o      (if_req),
        .if_addr_o     (if_addr),
        .if_gnt_i      (if_gnt),
        .if_rvalid_i   (if_rvalid),
        .fetch_valid_o (fetch_valid),
        .fetch_pc_o    (fetch_pc),
        .stall_i       (stall),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .trap_i        (trap),
        .epc_i         (epc),
        .trap_ret_i    (trap_ret),
        .mepc_o        (mepc),
        .misalign_o    (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of se_pc: loads npc every clock, resets asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 64'h0;
        else        pc <= npc;
    end

    function automatic vec_t mk(input logic g, input logic rv, input logic st,
                                input logic br, input logic [63:0] tgt,
                                input logic dl, input logic er,
                                input logic [63:0] epc_v, input logic efv,
                                input logic [63:0] enpc);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.stall = st; v.br = br; v.tgt = tgt;
        v.trap = F; v.ret = F; v.epc = 64'h0; v.deliver = dl;
        v.exp_req = er; v.exp_pc = epc_v; v.exp_fv = efv; v.exp_npc = enpc;
        v.exp_mis = F; v.exp_mepc = 64'h0;
        return v;
    endfunction

    function automatic vec_t ext(input vec_t vin, input logic tr, input logic rt,
                                 input logic [63:0] ep, input logic mis,
                                 input logic [63:0] mp);
        vec_t v;
        v = vin;
        v.trap = tr; v.ret = rt; v.epc = ep; v.exp_mis = mis; v.exp_mepc = mp;
        return v;
    endfunction

    task automatic chk(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic apply_row(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        if_gnt = v.gnt; if_rvalid = v.rvalid; stall = v.stall;
        br_taken = v.br; br_target = v.tgt;
        trap = v.trap; epc = v.epc; trap_ret = v.ret;
        if (v.gnt && v.deliver) exp_q.push_back(v.exp_pc);
        @(negedge clk);
        chk(tag, "if_req", 64'(if_req), 64'(v.exp_req));
        if (v.exp_req) chk(tag, "if_addr", if_addr, v.exp_pc);
        chk(tag, "fetch_valid", 64'(fetch_valid), 64'(v.exp_fv));
        if (v.exp_fv) chk(tag, "fetch_pc", fetch_pc, v.exp_pc);
        chk(tag, "npc", npc, v.exp_npc);
        chk(tag, "misalign", 64'(misalign), 64'(v.exp_mis));
        chk(tag, "mepc", mepc, v.exp_mepc);
        if (fetch_valid && v.rvalid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s.sb_fetch: got %h expected none queued", tag, fetch_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk(tag, "sb_fetch_pc", fetch_pc, e);
            end
        end
        $display("%s: pc=%h req=%b addr=%h fv=%b npc=%h mepc=%h mis=%b",
                 tag, pc, if_req, if_addr, fetch_valid, npc, mepc, misalign);
    endtask

    initial begin
        rst_n = 1'b1;
        if_gnt = F; if_rvalid = F; stall = F; br_taken = F; trap = F; trap_ret = F;
        br_target = 64'h0; epc = 64'h0;

        // Sequential fetches at 0,4,8,12 with immediate grant, rvalid +1
        tbl.push_back(mk(T,F,F,F,64'h0,   T,T,64'h0,  F,64'h0));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'h0,  T,64'h4));
        tbl.push_back(mk(T,F,F,F,64'h0,   T,T,64'h4,  F,64'h4));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'h4,  T,64'h8));
        tbl.push_back(mk(T,F,F,F,64'h0,   T,T,64'h8,  F,64'h8));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'h8,  T,64'hC));
        tbl.push_back(mk(T,F,F,F,64'h0,   T,T,64'hC,  F,64'hC));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'hC,  T,64'h10));
        // Stall held 3 cycles at 0x10
        tbl.push_back(mk(T,F,F,F,64'h0,   T,T,64'h10, F,64'h10));
        tbl.push_back(mk(F,T,T,F,64'h0,   F,F,64'h10, T,64'h10));
        tbl.push_back(mk(F,F,T,F,64'h0,   F,F,64'h10, T,64'h10));
        tbl.push_back(mk(F,F,T,F,64'h0,   F,F,64'h10, T,64'h10));
        tbl.push_back(mk(F,F,F,F,64'h0,   F,F,64'h10, T,64'h14));
        // Branch in WAIT before rvalid: response flushed
        tbl.push_back(mk(T,F,F,F,64'h0,   F,T,64'h14, F,64'h14));
        tbl.push_back(mk(F,F,F,T,64'h200, F,F,64'h14, F,64'h200));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'h200,F,64'h200));
        tbl.push_back(mk(T,F,F,F,64'h0,   T,T,64'h200,F,64'h200));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'h200,T,64'h204));
        // Branch beats same-cycle rvalid
        tbl.push_back(mk(T,F,F,F,64'h0,   F,T,64'h204,F,64'h204));
        tbl.push_back(mk(F,T,F,T,64'h300, F,F,64'h204,F,64'h300));
        tbl.push_back(mk(T,F,F,F,64'h0,   T,T,64'h300,F,64'h300));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'h300,T,64'h304));
        // Branches during REQ with grant delayed 2 cycles; second overwrites
        tbl.push_back(mk(F,F,F,T,64'h400, F,T,64'h304,F,64'h304));
        tbl.push_back(mk(F,F,F,T,64'h500, F,T,64'h304,F,64'h304));
        tbl.push_back(mk(T,F,F,F,64'h0,   F,T,64'h304,F,64'h500));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'h500,F,64'h500));
        tbl.push_back(mk(T,F,F,F,64'h0,   T,T,64'h500,F,64'h500));
        tbl.push_back(mk(F,T,F,F,64'h0,   F,F,64'h500,T,64'h504));

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", "npc", npc, 64'h0);
        chk("reset", "if_req", 64'(if_req), 64'h0);
        chk("reset", "fetch_valid", 64'(fetch_valid), 64'h0);
        chk("reset", "mepc", mepc, 64'h0);
        chk("reset", "misalign", 64'(misalign), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("idle", "if_req", 64'(if_req), 64'h0);
        chk("idle", "npc", npc, 64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_row(tbl[i], $sformatf("vec%0d", i));
        end

        // Trap + branch same cycle, then trap return
        apply_row(ext(mk(T,F,F,F,64'h0,  F,T,64'h504,F,64'h504), F,F,64'h0,F,64'h0), "trap_req");
        apply_row(ext(mk(F,T,F,T,64'h600,F,F,64'h504,F,64'h100), T,F,E,F,64'h0), "trap_hit");
        apply_row(ext(mk(T,F,F,F,64'h0,  F,T,64'h100,F,64'h100), F,F,64'h0,F,E), "trap_vec");
        apply_row(ext(mk(F,T,F,F,64'h0,  F,F,64'h100,F,E),       F,T,64'h0,F,E), "tret_hit");
        apply_row(ext(mk(T,F,F,F,64'h0,  T,T,E,F,E),             F,F,64'h0,F,E), "tret_req");
        apply_row(ext(mk(F,T,F,F,64'h0,  F,F,E,T,E4),            F,F,64'h0,F,E), "tret_fetch");
        // Misaligned branch target -> trap
        apply_row(ext(mk(T,F,F,F,64'h0,  F,T,E4,F,E4),           F,F,64'h0,F,E), "mis_req");
        apply_row(ext(mk(F,T,F,T,64'h202,F,F,E4,F,64'h100),      F,F,64'h0,F,E), "mis_hit");
        apply_row(ext(mk(T,F,F,F,64'h0,  F,T,64'h100,F,64'h100), F,F,64'h0,T,E4), "mis_pulse");
        // Wrap at top of address space
        apply_row(ext(mk(F,T,F,T,WR,     F,F,64'h100,F,WR),      F,F,64'h0,F,E4), "wrap_br");
        apply_row(ext(mk(T,F,F,F,64'h0,  T,T,WR,F,WR),           F,F,64'h0,F,E4), "wrap_req");
        apply_row(ext(mk(F,T,F,F,64'h0,  F,F,WR,T,64'h0),        F,F,64'h0,F,E4), "wrap_fetch");
        apply_row(ext(mk(T,F,F,F,64'h0,  T,T,64'h0,F,64'h0),     F,F,64'h0,F,E4), "post_wrap_req");
        apply_row(ext(mk(F,T,F,F,64'h0,  F,F,64'h0,T,64'h4),     F,F,64'h0,F,E4), "post_wrap_fetch");
        apply_row(ext(mk(T,F,F,F,64'h0,  T,T,64'h4,F,64'h4),     F,F,64'h0,F,E4), "rst_req");
        apply_row(ext(mk(F,T,T,F,64'h0,  F,F,64'h4,T,64'h4),     F,F,64'h0,F,E4), "rst_wait");

        // Asynchronous reset mid-WAIT, no clock edge involved
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", "npc", npc, 64'h0);
        chk("async_rst", "if_req", 64'(if_req), 64'h0);
        chk("async_rst", "fetch_valid", 64'(fetch_valid), 64'h0);
        chk("async_rst", "mepc", mepc, 64'h0);
        $display("async_rst: npc=%h req=%b fv=%b mepc=%h", npc, if_req, fetch_valid, mepc);
        if_gnt = F; stall = F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Idle after release ignores rvalid and redirects
        rst_n = 1'b1; if_rvalid = T; br_taken = T; br_target = 64'h700;
        #1;
        chk("idle2", "if_req", 64'(if_req), 64'h0);
        chk("idle2", "fetch_valid", 64'(fetch_valid), 64'h0);
        chk("idle2", "npc", npc, 64'h0);
        apply_row(mk(T,F,F,F,64'h0, T,T,64'h0,F,64'h0), "restart_req");
        apply_row(mk(F,T,F,F,64'h0, F,F,64'h0,T,64'h4), "restart_fetch");

        chk("end", "sb_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
